// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution stage.
//   BR_* : funct3 encodings of the conditional branches
//   br_upd_t : predictor update record {pc, taken, target} at the default
//              32-bit datapath width. The top module declares the same
//              layout at its own XLEN and hands it to the update FIFO as a
//              type parameter.
package br_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam int BR_XLEN = 32;

    typedef struct packed {
        logic [BR_XLEN-1:0] pc;
        logic               taken;
        logic [BR_XLEN-1:0] target;
    } br_upd_t;

endpackage

// File: rtl/br_upd_fifo.sv
// Update FIFO between branch resolution and the branch predictor.
// Count-based occupancy tracking, pointers wrap modulo DEPTH (power of two).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push       : write push_data this cycle
//   push_data  : entry to store
//   pop        : remove the head entry this cycle
//   head       : current head entry (combinational view of the oldest slot)
//   count      : number of stored entries, log2(DEPTH)+1 bits
//   empty      : no entries stored
module br_upd_fifo
    import br_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = br_upd_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));

    // A push into a full FIFO is allowed only when the head leaves in the
    // same cycle; the slot being written is then the one being vacated.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset; empty slots are never exposed by the top.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates B-type/JAL/JALR outcome, compares it
// with the front-end prediction, and emits a one-cycle result pulse from a
// single register stage (S1). Resolved outcomes are queued for the branch
// predictor; saturating branch/mispredict counters are kept.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid/in_ready                : instruction handshake
//   in_pc, in_op1, in_op2, in_imm    : PC, rs1, rs2, sign-extended immediate
//   in_funct3, in_jump, in_jalr      : branch type / unconditional / JALR
//   in_pred_taken, in_pred_target    : front-end prediction
//   flush                            : squash S1 and same-cycle input
//   res_valid, res_taken,
//   res_mispredict, res_redirect_pc  : resolution pulse (N+1)
//   upd_valid/upd_ready, upd_pc,
//   upd_taken, upd_target            : predictor update stream (FIFO head)
//   cnt_branches, cnt_mispred        : saturating performance counters
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_funct3,
    input  logic             in_jump,
    input  logic             in_jalr,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_redirect_pc,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [XLEN-1:0]  upd_pc,
    output logic [XLEN-1:0]  upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int CW = $clog2(UPD_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } upd_entry_t;

    // ---------------- combinational resolution ----------------
    logic            cond;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic            taken;
    logic            mispredict;
    logic            accept;

    always_comb begin
        cond = 1'b0;
        case (in_funct3)
            BR_BEQ:  cond = (in_op1 == in_op2);
            BR_BNE:  cond = (in_op1 != in_op2);
            BR_BLT:  cond = ($signed(in_op1) <  $signed(in_op2));
            BR_BGE:  cond = ($signed(in_op1) >= $signed(in_op2));
            BR_BLTU: cond = (in_op1 <  in_op2);
            BR_BGEU: cond = (in_op1 >= in_op2);
            default: cond = 1'b0;
        endcase
    end

    // in_jalr only has meaning together with in_jump.
    assign target_sum   = (in_jump & in_jalr) ? (in_op1 + in_imm) : (in_pc + in_imm);
    assign target       = (in_jump & in_jalr) ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    assign fall_through = in_pc + XLEN'(4);
    assign taken        = in_jump | (~in_jump & cond);
    assign mispredict   = (taken != in_pred_taken) | (taken & (target != in_pred_target));
    assign accept       = in_valid & in_ready & ~flush;

    // ---------------- S1 register ----------------
    logic            s1_valid_reg;
    logic            s1_taken_reg;
    logic            s1_mispredict_reg;
    logic [XLEN-1:0] s1_redirect_reg;
    logic [XLEN-1:0] s1_pc_reg;
    logic [XLEN-1:0] s1_target_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg      <= 1'b0;
            s1_taken_reg      <= 1'b0;
            s1_mispredict_reg <= 1'b0;
            s1_redirect_reg   <= '0;
            s1_pc_reg         <= '0;
            s1_target_reg     <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_taken_reg      <= taken;
                s1_mispredict_reg <= mispredict;
                s1_redirect_reg   <= taken ? target : fall_through;
                s1_pc_reg         <= in_pc;
                s1_target_reg     <= target;
            end
        end
    end

    assign res_valid       = s1_valid_reg & ~flush;
    assign res_taken       = s1_taken_reg;
    assign res_mispredict  = s1_mispredict_reg;
    assign res_redirect_pc = s1_redirect_reg;

    // ---------------- update FIFO ----------------
    logic          push;
    logic          pop;
    upd_entry_t    push_data;
    upd_entry_t    head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [CW:0]   occupancy;

    assign push      = res_valid;
    assign pop       = upd_valid & upd_ready;
    assign push_data = '{pc: s1_pc_reg, taken: s1_taken_reg, target: s1_target_reg};

    br_upd_fifo #(
        .DEPTH   (UPD_DEPTH),
        .entry_t (upd_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign upd_valid  = ~fifo_empty;
    // Head slot contents are only meaningful when an entry is present.
    assign upd_pc     = upd_valid ? head.pc     : '0;
    assign upd_taken  = upd_valid ? head.taken  : 1'b0;
    assign upd_target = upd_valid ? head.target : '0;

    // Counting S1 as occupied reserves a FIFO slot for it, so S1 never stalls.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_reg};
    assign in_ready  = (occupancy < (CW+1)'(UPD_DEPTH));

    // ---------------- performance counters ----------------
    logic [CNT_W-1:0] cnt_branches_reg;
    logic [CNT_W-1:0] cnt_mispred_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branches_reg <= '0;
            cnt_mispred_reg  <= '0;
        end else if (push) begin
            if (cnt_branches_reg != '1)
                cnt_branches_reg <= cnt_branches_reg + 1'b1;
            if (s1_mispredict_reg && (cnt_mispred_reg != '1))
                cnt_mispred_reg <= cnt_mispred_reg + 1'b1;
        end
    end

    assign cnt_branches = cnt_branches_reg;
    assign cnt_mispred  = cnt_mispred_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc, in_op1, in_op2, in_imm, in_pred_target;
    logic [2:0]       in_funct3;
    logic             in_jump, in_jalr, in_pred_taken;
    logic             flush;
    logic             res_valid, res_taken, res_mispredict;
    logic [XLEN-1:0]  res_redirect_pc;
    logic             upd_valid, upd_ready, upd_taken;
    logic [XLEN-1:0]  upd_pc, upd_target;
    logic [CNT_W-1:0] cnt_branches, cnt_mispred;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .UPD_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op1(in_op1), .in_op2(in_op2), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_jump(in_jump), .in_jalr(in_jalr),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .flush(flush),
        .res_valid(res_valid), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .res_redirect_pc(res_redirect_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm, input logic [2:0] f3, input logic jump,
                         input logic jalr, input logic pt, input logic [31:0] ptgt);
        in_valid = 1'b1; in_pc = pc; in_op1 = op1; in_op2 = op2; in_imm = imm;
        in_funct3 = f3; in_jump = jump; in_jalr = jalr;
        in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    // One isolated branch: accept, check the N+1 pulse, then let it push.
    task automatic one_branch(input string tag, input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] imm, input logic [2:0] f3,
                              input logic jump, input logic jalr, input logic pt,
                              input logic [31:0] ptgt, input logic exp_taken,
                              input logic exp_mis, input logic [31:0] exp_redir);
        drive(pc, op1, op2, imm, f3, jump, jalr, pt, ptgt);
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_taken"}, 64'(res_taken), 64'(exp_taken));
        chk({tag, "_mispred"}, 64'(res_mispredict), 64'(exp_mis));
        chk({tag, "_redirect"}, 64'(res_redirect_pc), 64'(exp_redir));
        step();
        $display("txn %s pc=%08h taken=%0b mispred=%0b redirect=%08h", tag, pc,
                 res_taken, res_mispredict, res_redirect_pc);
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; upd_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        in_valid = 1'b0;
        step(); step();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_redirect", 64'(res_redirect_pc), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_upd_pc", 64'(upd_pc), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_cnt_br", 64'(cnt_branches), 64'd0);
        rst_n = 1'b1;
        step();

        // BLT signed: -1 < 1, mispredicted direction; check latency.
        drive(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("blt_valid", 64'(res_valid), 64'd1);
        chk("blt_taken", 64'(res_taken), 64'd1);
        chk("blt_mispred", 64'(res_mispredict), 64'd1);
        chk("blt_redirect", 64'(res_redirect_pc), 64'h120);
        chk("blt_upd_n1", 64'(upd_valid), 64'd0);
        step();
        $display("txn blt pc=00000100 accepted, update now visible");
        chk("blt_res_gone", 64'(res_valid), 64'd0);
        chk("blt_upd_n2", 64'(upd_valid), 64'd1);
        chk("blt_upd_pc", 64'(upd_pc), 64'h100);
        chk("blt_upd_taken", 64'(upd_taken), 64'd1);
        chk("blt_upd_tgt", 64'(upd_target), 64'h120);
        chk("blt_cnt_br", 64'(cnt_branches), 64'd1);
        chk("blt_cnt_mis", 64'(cnt_mispred), 64'd1);
        upd_ready = 1'b1;
        step();
        chk("blt_popped", 64'(upd_valid), 64'd0);

        one_branch("bltu", 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'b110, 1'b0, 1'b0,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        one_branch("jalr", 32'h200, 32'h203, 32'h0, 32'h0, 3'b000, 1'b1, 1'b1,
                   1'b1, 32'h202, 1'b1, 1'b0, 32'h202);
        one_branch("wrap_tk", 32'hFFFF_FFFC, 32'h5, 32'h5, 32'h8, 3'b000, 1'b0, 1'b0,
                   1'b1, 32'h4, 1'b1, 1'b0, 32'h4);
        one_branch("wrap_nt", 32'hFFFF_FFFC, 32'h5, 32'h5, 32'h8, 3'b001, 1'b0, 1'b0,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        one_branch("rsvd", 32'h300, 32'h7, 32'h7, 32'h40, 3'b010, 1'b0, 1'b0,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
        one_branch("bge", 32'h380, 32'h1, 32'hFFFF_FFFF, 32'h10, 3'b101, 1'b0, 1'b0,
                   1'b1, 32'h390, 1'b1, 1'b0, 32'h390);
        one_branch("tgt_mis", 32'h400, 32'h1, 32'h2, 32'h10, 3'b001, 1'b0, 1'b0,
                   1'b1, 32'h999, 1'b1, 1'b1, 32'h410);
        chk("dir_cnt_br", 64'(cnt_branches), 64'd8);
        chk("dir_cnt_mis", 64'(cnt_mispred), 64'd2);
        chk("dir_drained", 64'(upd_valid), 64'd0);

        // Backpressure: four accepted, fifth held off until a pop.
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h1000 + 32'(i * 4), 32'h3, 32'h3, 32'h40, 3'b000, 1'b0, 1'b0,
                  1'b1, 32'h1040 + 32'(i * 4));
            chk("bp_ready", 64'(in_ready), 64'd1);
            step();
            $display("txn bp accept pc=%08h", 32'h1000 + 32'(i * 4));
        end
        drive(32'h1010, 32'h3, 32'h3, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h1050);
        chk("bp_blocked", 64'(in_ready), 64'd0);
        step();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head0", 64'(upd_pc), 64'h1000);
        upd_ready = 1'b1;
        step();
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_head1", 64'(upd_pc), 64'h1004);
        step();
        in_valid = 1'b0;
        chk("bp_head2", 64'(upd_pc), 64'h1008);
        step();
        chk("bp_head3", 64'(upd_pc), 64'h100C);
        step();
        chk("bp_head4", 64'(upd_pc), 64'h1010);
        chk("bp_tgt4", 64'(upd_target), 64'h1050);
        step();
        chk("bp_empty", 64'(upd_valid), 64'd0);
        chk("bp_cnt_br", 64'(cnt_branches), 64'd13);
        $display("txn bp drained cnt_branches=%0d", cnt_branches);

        // Flush: one entry already queued, S1 and a same-cycle input squashed.
        upd_ready = 1'b0;
        drive(32'h500, 32'h9, 32'h9, 32'h8, 3'b000, 1'b0, 1'b0, 1'b1, 32'h508);
        step();
        in_valid = 1'b0;
        step();
        drive(32'h600, 32'h9, 32'h9, 32'h8, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(32'h700, 32'h9, 32'h9, 32'h8, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("fl_res_valid", 64'(res_valid), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_no_accept", 64'(res_valid), 64'd0);
        chk("fl_cnt_br", 64'(cnt_branches), 64'd14);
        chk("fl_cnt_mis", 64'(cnt_mispred), 64'd2);
        chk("fl_head", 64'(upd_pc), 64'h500);
        upd_ready = 1'b1;
        step();
        chk("fl_only_one", 64'(upd_valid), 64'd0);
        $display("txn flush squashed pc=00000600 and pc=00000700");

        // Saturation: 20 mispredicting taken branches back to back.
        for (int i = 0; i < 20; i++) begin
            drive(32'h2000 + 32'(i * 4), 32'h1, 32'h1, 32'h10, 3'b000, 1'b0, 1'b0,
                  1'b0, 32'h0);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("sat_cnt_br", 64'(cnt_branches), 64'd15);
        chk("sat_cnt_mis", 64'(cnt_mispred), 64'd15);
        $display("txn saturate cnt_branches=%0d cnt_mispred=%0d", cnt_branches, cnt_mispred);

        // Asynchronous reset mid-stream.
        upd_ready = 1'b0;
        drive(32'h3000, 32'h1, 32'h2, 32'h10, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("ar_res_valid", 64'(res_valid), 64'd0);
        chk("ar_res_taken", 64'(res_taken), 64'd0);
        chk("ar_redirect", 64'(res_redirect_pc), 64'd0);
        chk("ar_upd_valid", 64'(upd_valid), 64'd0);
        chk("ar_upd_pc", 64'(upd_pc), 64'd0);
        chk("ar_cnt_br", 64'(cnt_branches), 64'd0);
        chk("ar_cnt_mis", 64'(cnt_mispred), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("ar_no_pulse", 64'(res_valid), 64'd0);
        $display("txn async reset cleared state");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the RISC-V core. Accepts one B-type, JAL or JALR instruction per cycle, evaluates the branch condition at XLEN width, and computes the actual target. It compares the result against the front-end prediction and raises a one-cycle mispredict/redirect. Resolved outcomes are buffered in an update FIFO that drains to the branch predictor under a valid/ready handshake; saturating performance counters are kept alongside.

## Interface
Parameters:
- XLEN, 32, datapath and PC width (32 or 64)
- UPD_DEPTH, 4, update FIFO depth; power of two, ≥2
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_op1, in_op2  in  XLEN  rs1/rs2 values
- in_imm  in  XLEN  sign-extended immediate
- in_funct3  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- in_jump  in  1  JAL/JALR: unconditional, funct3 ignored
- in_jalr  in  1  target from op1 (valid only with in_jump)
- in_pred_taken  in  1  front-end predicted direction
- in_pred_target  in  XLEN  front-end predicted target
- flush  in  1  squash in-flight (younger) work
- res_valid  out  1  resolution result valid this cycle
- res_taken  out  1  actual direction
- res_mispredict  out  1  direction or target wrong
- res_redirect_pc  out  XLEN  correct next PC
- upd_valid  out  1  predictor update available
- upd_ready  in  1  predictor accepts update
- upd_pc, upd_target  out  XLEN  update PC / actual target
- upd_taken  out  1  update direction
- cnt_branches, cnt_mispred  out  CNT_W  saturating counters

## Operation
- Condition: BEQ/BNE equality, BLT/BGE signed, BLTU/BGEU unsigned, all at XLEN. Reserved funct3 (010, 011) with in_jump=0 → taken=0, never mispredicts on target.
- Target: in_jalr ? ((op1+imm) & ~1) : (pc+imm). Modulo 2^XLEN, carry discarded. Fall-through is pc+4, also modulo 2^XLEN.
- taken = in_jump | cond.
- mispredict = (taken ≠ pred_taken) | (taken & target ≠ pred_target).
- redirect_pc = taken ? target : pc+4.
- Single stage register (S1) holds the computed result. There is no S1-stage handshake: results are pulses.
- in_ready = (fifo_count + s1_valid) < UPD_DEPTH. This reserves FIFO room, so S1 never stalls.
- res_valid = s1_valid & ~flush. The res_* data fields are registered.
- At the end of each cycle with res_valid=1, {pc, taken, target} is pushed to the FIFO.
- cnt_branches increments on every push. cnt_mispred increments on every push with mispredict. Both saturate at all-ones.
- FIFO pops on upd_valid & upd_ready. Simultaneous push and pop leaves the count unchanged. upd_* show the head entry.
- Flush:
  - S1 is dropped (no push, no count).
  - An input accepted in the same cycle is discarded.
  - FIFO contents are kept, because those entries are architecturally resolved.

## Timing
- Accept in cycle N → res_* valid in N+1 → earliest upd_valid in N+2.
- Throughput is one per cycle while the FIFO is not backpressured.
- Reset values: s1_valid=0, all res_*=0, FIFO empty, upd_valid=0, upd_* fields=0, counters=0, in_ready=1.
- Reset mid-operation clears S1, the FIFO and the counters immediately, with no pending pulse.
- Full: in_ready drops once fifo_count+s1_valid=UPD_DEPTH. It rises the cycle after a pop frees space.
- Empty: upd_valid=0. A push into an empty FIFO is visible on the next cycle (no bypass).
- Pointers wrap modulo UPD_DEPTH. The count uses log2(UPD_DEPTH)+1 bits.

## Structure
- Package br_pkg holds:
  - BR_BEQ…BR_BGEU funct3 localparams
  - typedef br_upd_t {pc, taken, target}, parametrised by XLEN via package parameter or macro
- Sub-module br_upd_fifo: synchronous, single clock, UPD_DEPTH entries of br_upd_t, count-based full/empty.
- Comparator and target logic are inline.

## Test plan
- BLT op1=0xFFFFFFFF, op2=1, pred_taken=0, pc=0x100, imm=0x20 → taken=1, mispredict=1, redirect 0x120 at N+1, upd_valid at N+2.
- BLTU same operands, pred_taken=0 → taken=0, mispredict=0, redirect 0x104. JALR op1=0x203, imm=0 → target 0x202.
- Target wrap: pc=0xFFFFFFFC, BEQ equal, imm=8, pred_target=4 → target 0x4, mispredict=0. Not-taken redirect 0x0.
- Backpressure: upd_ready=0, stream 5 branches with UPD_DEPTH=4 → in_ready low after 4 accepted. Raise upd_ready → pops in order, in_ready returns the next cycle.
- Flush in cycle N+1 with S1 valid → res_valid=0, no push, counters unchanged. Prior FIFO entries still drain.
- Saturation with CNT_W=4: 20 mispredicting branches → both counters stop at 15. Assert rst_n mid-stream → counters, FIFO and outputs return to 0 asynchronously.
